// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised 3-read/1-write register file with hardware clear sequencer
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass on same-cycle address match).
module regfile_multiport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regread,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] readregsrc1,
    input  logic [ADDR_W-1:0] readregsrc2,
    input  logic [ADDR_W-1:0] readregsrc3,
    input  logic [ADDR_W-1:0] regwritedst,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              rvalid,
    output logic              busy,
    output logic              drop
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              last_idx;

    assign last_idx = &idx;
    assign busy     = (state == CLEAR);
    assign wr_en    = regwrite && !((ZERO_REG != 0) && (regwritedst == '0));

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (last_idx) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) idx <= idx + 1'b1;
        end
    end

    // Read-port mux: zero register masking first, then optional bypass, else memory.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (regwrite && (addr == regwritedst)) v = writedata;
`endif
        if ((ZERO_REG != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[idx] <= '0;
            else if (wr_en)
                mem[regwritedst] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            c      <= '0;
            rvalid <= 1'b0;
            drop   <= 1'b0;
        end else if (state == CLEAR) begin
            rvalid <= 1'b0;
            drop   <= regread | regwrite;
        end else begin
            drop   <= 1'b0;
            rvalid <= regread;
            if (regread) begin
                a <= rd(readregsrc1);
                b <= rd(readregsrc2);
                c <= rd(readregsrc3);
            end
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;
    logic        clk = 1'b0;
    logic        rst;
    logic        regread, regwrite;
    logic [3:0]  readregsrc1, readregsrc2, readregsrc3, regwritedst;
    logic [15:0] writedata;
    logic [15:0] a, b, c, za, zb, zc;
    logic        rvalid, busy, drop, zrvalid, zbusy, zdrop;
    int          errors = 0;
    int          checks = 0;
    int          n;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .regread(regread), .regwrite(regwrite),
        .readregsrc1(readregsrc1), .readregsrc2(readregsrc2), .readregsrc3(readregsrc3),
        .regwritedst(regwritedst), .writedata(writedata),
        .a(a), .b(b), .c(c), .rvalid(rvalid), .busy(busy), .drop(drop)
    );

    regfile_multiport #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dutz (
        .clk(clk), .rst(rst), .regread(regread), .regwrite(regwrite),
        .readregsrc1(readregsrc1), .readregsrc2(readregsrc2), .readregsrc3(readregsrc3),
        .regwritedst(regwritedst), .writedata(writedata),
        .a(za), .b(zb), .c(zc), .rvalid(zrvalid), .busy(zbusy), .drop(zdrop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd3(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        regread = 1'b1; readregsrc1 = s1; readregsrc2 = s2; readregsrc3 = s3;
        tick();
        regread = 1'b0;
    endtask

    task automatic wr(input logic [3:0] dst, input logic [15:0] d);
        regwrite = 1'b1; regwritedst = dst; writedata = d;
        tick();
        regwrite = 1'b0;
    endtask

    // Counts cycles until busy falls, starting from a given count; bounded.
    task automatic wait_idle(input int start, output int cnt, input string tag);
        cnt = start;
        while (busy && cnt < 64) begin
            tick();
            cnt++;
            if (rvalid) chk({tag, "_rvalid_in_clear"}, rvalid, 0);
        end
        chk({tag, "_busy_cycles"}, cnt, 16);
    endtask

    initial begin
        rst = 1'b1; regread = 0; regwrite = 0;
        readregsrc1 = 0; readregsrc2 = 0; readregsrc3 = 0; regwritedst = 0; writedata = 0;
        tick(); tick();
        chk("rst_busy", busy, 1);
        chk("rst_a", a, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_drop", drop, 0);
        rst = 1'b0;
        wait_idle(0, n, "init");
        chk("init_zbusy", zbusy, 0);

        rd3(4'd0, 4'd7, 4'd15);
        chk("r0", a, 0); chk("r7", b, 0); chk("r15", c, 0);
        chk("rd_rvalid", rvalid, 1);
        tick();
        chk("rd_rvalid_pulse", rvalid, 0);

        wr(4'd5, 16'hBEEF);
        rd3(4'd5, 4'd5, 4'd6);
        chk("wr_a", a, 16'hBEEF); chk("wr_b", b, 16'hBEEF); chk("wr_c", c, 16'h0000);
        chk("wr_rvalid", rvalid, 1);
        tick();
        chk("wr_rvalid_off", rvalid, 0);
        chk("hold_a", a, 16'hBEEF);

        wr(4'd3, 16'h1111);
        regwrite = 1'b1; regwritedst = 4'd3; writedata = 16'h2222;
        rd3(4'd3, 4'd3, 4'd5);
        regwrite = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("simul_a", a, 16'h2222);
`else
        chk("simul_a", a, 16'h1111);
`endif
        chk("simul_c", c, 16'hBEEF);
        rd3(4'd3, 4'd3, 4'd3);
        chk("after_simul_a", a, 16'h2222);

        wr(4'd0, 16'h1234);
        chk("zr_drop", zdrop, 0);
        rd3(4'd0, 4'd0, 4'd0);
        chk("zr_a", za, 16'h0000);
        chk("nozr_a", a, 16'h1234);
        chk("run_drop", drop, 0);

        wr(4'd10, 16'hAAAA);
        rd3(4'd10, 4'd0, 4'd0);
        chk("r10_pre", a, 16'hAAAA);

        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("midclr_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midclr_rst_busy", busy, 1);
        tick(); tick();
        regwrite = 1'b1; regwritedst = 4'd2; writedata = 16'h5555;
        tick();
        regwrite = 1'b0;
        chk("busy_drop", drop, 1);
        chk("busy_rvalid", rvalid, 0);
        tick();
        chk("busy_drop_pulse", drop, 0);
        wait_idle(4, n, "midclr");

        rd3(4'd10, 4'd2, 4'd5);
        chk("r10_cleared", a, 16'h0000);
        chk("r2_not_written", b, 16'h0000);
        chk("r5_cleared", c, 16'h0000);
        chk("post_rvalid", rvalid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
